// File: rtl/operand_stack_nbits_if.sv
// Operation and status bundle of the operand stack.
// The master issues one op per cycle; the slave returns the registered stack view.
interface operand_stack_nbits_if #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 8
);
    localparam int unsigned CW = $clog2(depth + 1);

    logic [2:0]       op_i;
    logic [width-1:0] d_i;
    logic [width-1:0] top_o;
    logic [width-1:0] next_o;
    logic [CW-1:0]    count_o;
    logic             empty_o;
    logic             full_o;
    logic             err_o;

    modport master (
        output op_i, d_i,
        input  top_o, next_o, count_o, empty_o, full_o, err_o
    );

    modport slave (
        input  op_i, d_i,
        output top_o, next_o, count_o, empty_o, full_o, err_o
    );
endinterface

// File: rtl/operand_stack_nbits.sv
// LIFO operand stack: register array plus stack pointer, with the top two
// entries kept in dedicated registers so the ALU sees them with no read mux.
module operand_stack_nbits #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 8
) (
    input  logic clock_i,
    input  logic reset_i,
    operand_stack_nbits_if.slave bus
);
    localparam int unsigned CW = $clog2(depth + 1);
    localparam int unsigned AW = (depth > 1) ? $clog2(depth) : 1;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_DUP     = 3'd3,
        OP_SWAP    = 3'd4,
        OP_REPLACE = 3'd5,
        OP_CLEAR   = 3'd6,
        OP_NOP7    = 3'd7
    } op_e;

    logic [width-1:0] mem_q [depth];
    logic [width-1:0] mem_n [depth];
    logic [CW-1:0]    count_q, count_n;
    logic [width-1:0] top_q, top_n;
    logic [width-1:0] next_q, next_n;
    logic             err_q, err_n;
    logic             empty_q, full_q;

    op_e              op;
    logic             has1, has2, has3, room;
    logic [AW-1:0]    idx_free, idx_top, idx_next, idx_third;
    logic [width-1:0] below;

    assign op   = op_e'(bus.op_i);
    assign has1 = (count_q >= CW'(1));
    assign has2 = (count_q >= CW'(2));
    assign has3 = (count_q >= CW'(3));
    assign room = (count_q <  CW'(depth));

    // Slot indices relative to the pointer; only used when the matching guard holds.
    assign idx_free  = AW'(count_q);
    assign idx_top   = AW'(count_q - CW'(1));
    assign idx_next  = AW'(count_q - CW'(2));
    assign idx_third = AW'(count_q - CW'(3));

    // Entry that becomes next_o once the top is consumed.
    assign below = has3 ? mem_q[idx_third] : '0;

    // Next-state for storage, pointer, cached top/next and the sticky error.
    always_comb begin
        mem_n   = mem_q;
        count_n = count_q;
        top_n   = top_q;
        next_n  = next_q;
        err_n   = err_q;
        case (op)
            OP_PUSH: begin
                if (room) begin
                    mem_n[idx_free] = bus.d_i;
                    count_n         = count_q + CW'(1);
                    top_n           = bus.d_i;
                    next_n          = top_q;
                end else begin
                    err_n = 1'b1;
                end
            end
            OP_POP: begin
                if (has1) begin
                    count_n = count_q - CW'(1);
                    top_n   = next_q;
                    next_n  = below;
                end else begin
                    err_n = 1'b1;
                end
            end
            OP_DUP: begin
                if (has1 && room) begin
                    mem_n[idx_free] = top_q;
                    count_n         = count_q + CW'(1);
                    next_n          = top_q;
                end else begin
                    err_n = 1'b1;
                end
            end
            OP_SWAP: begin
                if (has2) begin
                    mem_n[idx_top]  = next_q;
                    mem_n[idx_next] = top_q;
                    top_n           = next_q;
                    next_n          = top_q;
                end else begin
                    err_n = 1'b1;
                end
            end
            OP_REPLACE: begin
                if (has2) begin
                    mem_n[idx_next] = bus.d_i;
                    count_n         = count_q - CW'(1);
                    top_n           = bus.d_i;
                    next_n          = below;
                end else begin
                    err_n = 1'b1;
                end
            end
            OP_CLEAR: begin
                count_n = '0;
                top_n   = '0;
                next_n  = '0;
                err_n   = 1'b0;
            end
            default: ;
        endcase
    end

    // State registers; reset wins over any op sampled on the same edge.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(depth); i++) begin
                mem_q[i] <= '0;
            end
            count_q <= '0;
            top_q   <= '0;
            next_q  <= '0;
            err_q   <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            mem_q   <= mem_n;
            count_q <= count_n;
            top_q   <= top_n;
            next_q  <= next_n;
            err_q   <= err_n;
            empty_q <= (count_n == '0);
            full_q  <= (count_n == CW'(depth));
        end
    end

    assign bus.top_o   = top_q;
    assign bus.next_o  = next_q;
    assign bus.count_o = count_q;
    assign bus.empty_o = empty_q;
    assign bus.full_o  = full_q;
    assign bus.err_o   = err_q;
endmodule

// File: tb/tb_operand_stack_nbits.sv
// Scoreboard bench: stimulus pushes queue-model expectations, monitor checks outputs.
module tb_operand_stack_nbits;
    localparam int unsigned W  = 8;
    localparam int unsigned D  = 8;
    localparam int unsigned CW = $clog2(D + 1);

    typedef struct {
        logic [W-1:0]  top;
        logic [W-1:0]  nxt;
        logic [CW-1:0] cnt;
        logic          empty;
        logic          full;
        logic          err;
    } exp_t;

    logic clock_i = 1'b0;
    logic reset_i = 1'b1;

    operand_stack_nbits_if #(.width(W), .depth(D)) bus ();

    operand_stack_nbits #(.width(W), .depth(D)) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clock_i = ~clock_i;

    exp_t         exp_q[$];
    logic [W-1:0] stk[$];
    logic         m_err = 1'b0;
    int           checks = 0;
    int           failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a plain queue whose back is the top of stack.
    task automatic model(input logic rst, input logic [2:0] op, input logic [W-1:0] d);
        exp_t e;
        logic [W-1:0] a, b;
        if (rst) begin
            stk.delete();
            m_err = 1'b0;
        end else begin
            case (op)
                3'd1: if (stk.size() < D) stk.push_back(d); else m_err = 1'b1;
                3'd2: if (stk.size() >= 1) void'(stk.pop_back()); else m_err = 1'b1;
                3'd3: if (stk.size() >= 1 && stk.size() < D) stk.push_back(stk[$]); else m_err = 1'b1;
                3'd4: if (stk.size() >= 2) begin
                          a = stk.pop_back(); b = stk.pop_back();
                          stk.push_back(a); stk.push_back(b);
                      end else m_err = 1'b1;
                3'd5: if (stk.size() >= 2) begin
                          void'(stk.pop_back()); void'(stk.pop_back());
                          stk.push_back(d);
                      end else m_err = 1'b1;
                3'd6: begin stk.delete(); m_err = 1'b0; end
                default: ;
            endcase
        end
        e.cnt   = CW'(stk.size());
        e.top   = (stk.size() >= 1) ? stk[stk.size()-1] : '0;
        e.nxt   = (stk.size() >= 2) ? stk[stk.size()-2] : '0;
        e.empty = (stk.size() == 0);
        e.full  = (stk.size() == D);
        e.err   = m_err;
        exp_q.push_back(e);
    endtask

    task automatic apply(input logic rst, input logic [2:0] op, input logic [W-1:0] d);
        @(negedge clock_i);
        reset_i  = rst;
        bus.op_i = op;
        bus.d_i  = d;
        model(rst, op, d);
    endtask

    // Monitor: every edge that consumed an op yields one expectation to check.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("top",   int'(bus.top_o),   int'(e.top));
                chk("next",  int'(bus.next_o),  int'(e.nxt));
                chk("count", int'(bus.count_o), int'(e.cnt));
                chk("empty", int'(bus.empty_o), int'(e.empty));
                chk("full",  int'(bus.full_o),  int'(e.full));
                chk("err",   int'(bus.err_o),   int'(e.err));
            end
        end
    end

    initial begin
        int r;
        int waited;
        bus.op_i = 3'd0;
        bus.d_i  = '0;
        apply(1'b1, 3'd1, 8'hFF);
        apply(1'b1, 3'd0, 8'h00);
        // Basic push / swap / replace
        apply(1'b0, 3'd1, 8'h11);
        apply(1'b0, 3'd1, 8'h22);
        apply(1'b0, 3'd1, 8'h33);
        apply(1'b0, 3'd4, 8'h00);
        apply(1'b0, 3'd5, 8'h55);
        // Overflow, sticky error, clear
        for (int i = 0; i < 7; i++) apply(1'b0, 3'd1, 8'(8'h60 + i));
        apply(1'b0, 3'd1, 8'hAA);
        apply(1'b0, 3'd2, 8'h00);
        apply(1'b0, 3'd6, 8'h00);
        // Underflow on empty, then push and dup
        apply(1'b0, 3'd2, 8'h00);
        apply(1'b0, 3'd6, 8'h00);
        apply(1'b0, 3'd1, 8'h07);
        apply(1'b0, 3'd3, 8'h00);
        // Single entry: swap and replace are illegal
        apply(1'b0, 3'd6, 8'h00);
        apply(1'b0, 3'd1, 8'h42);
        apply(1'b0, 3'd4, 8'h00);
        apply(1'b0, 3'd5, 8'h99);
        // Reset with a concurrent push at count 5
        for (int i = 0; i < 4; i++) apply(1'b0, 3'd1, 8'(8'hC0 + i));
        apply(1'b1, 3'd1, 8'hEE);
        // Randomised ops, biased toward push so the full boundary is reached
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 9));
            apply(($urandom_range(0, 59) == 0), (r >= 8) ? 3'd1 : 3'(r), 8'($urandom));
        end
        apply(1'b0, 3'd0, 8'h00);
        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clock_i);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) chk("drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
